// File: rtl/crc_pkg.sv
// crc_pkg: shared constants and types for the CRC-16/XMODEM encode path and
// its receive-side checker.
//   DATA_W / CRC_W     : data word and CRC widths; a codeword is {data, crc}
//   CRC_POLY / CRC_INIT: generator polynomial (x^16 implicit) and LFSR seed
//   state_t            : encoder FSM states
//   codeword_t         : full codeword vector
package crc_pkg;

    localparam int DATA_W = 16;
    localparam int CRC_W  = 16;
    localparam int CW_W   = DATA_W + CRC_W;
    localparam int CNT_W  = 5;

    localparam logic [CRC_W-1:0] CRC_POLY = 16'h1021;
    localparam logic [CRC_W-1:0] CRC_INIT = 16'h0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef logic [CW_W-1:0] codeword_t;

endpackage

// File: rtl/crc_lfsr_step.sv
// crc_lfsr_step: combinational single-bit CRC LFSR update (MSB first, no
// reflection). Shared with the receive-side checker so both ends use
// identical polynomial logic.
//   crc_in  : current LFSR contents
//   bit_in  : next message bit
//   poly    : generator polynomial without the implicit top term
//   crc_out : LFSR contents after absorbing bit_in
module crc_lfsr_step
    import crc_pkg::*;
#(
    parameter int W = CRC_W
) (
    input  logic [W-1:0] crc_in,
    input  logic         bit_in,
    input  logic [W-1:0] poly,
    output logic [W-1:0] crc_out
);

    logic fb;

    assign fb      = crc_in[W-1] ^ bit_in;
    assign crc_out = {crc_in[W-2:0], 1'b0} ^ (fb ? poly : '0);

endmodule

// File: rtl/crc_encoder.sv
// crc_encoder: accepts a 16-bit data word, runs it MSB first through a
// bit-serial CRC LFSR (one bit per clock) and presents the codeword
// {data, crc} ^ errMask. The mask lets the correction path be exercised with
// controlled bit errors.
//   clk, rst  : clock (rising edge), asynchronous active-high reset
//   dInValid  : input word valid
//   dIn       : data word, sampled only at the acceptance edge
//   errMask   : codeword XOR mask, sampled together with dIn
//   dInReady  : high only while idle
//   cwValid   : codeword valid (driven from state only)
//   cw        : registered codeword, held stable while cwReady is low
//   cwReady   : downstream accepts the codeword
//   busy      : a word is in flight (SHIFT or DONE)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid, once raised, stays high with stable data until that
// transfer, and never depends combinationally on ready.
module crc_encoder
    import crc_pkg::*;
#(
    parameter logic [CRC_W-1:0] POLY = CRC_POLY,
    parameter logic [CRC_W-1:0] INIT = CRC_INIT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   dInValid,
    input  logic [DATA_W-1:0]      dIn,
    input  logic [DATA_W+CRC_W-1:0] errMask,
    output logic                   dInReady,
    output logic                   cwValid,
    output logic [DATA_W+CRC_W-1:0] cw,
    input  logic                   cwReady,
    output logic                   busy
);

    state_t              state;
    state_t              state_next;

    logic [DATA_W-1:0]   data_q;
    logic [DATA_W-1:0]   sh_q;
    codeword_t           mask_q;
    codeword_t           cw_q;
    logic [CRC_W-1:0]    crc_q;
    logic [CRC_W-1:0]    crc_next;
    logic [CNT_W-1:0]    cnt_q;

    logic                accept;
    logic                last_bit;

    assign accept   = (state == IDLE) && dInValid;
    assign last_bit = (state == SHIFT) && (cnt_q == CNT_W'(DATA_W - 1));

    crc_lfsr_step #(
        .W (CRC_W)
    ) u_step (
        .crc_in  (crc_q),
        .bit_in  (sh_q[DATA_W-1]),
        .poly    (POLY),
        .crc_out (crc_next)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)   state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    if (cwReady)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: load on acceptance, shift one bit per SHIFT cycle, capture
    // the codeword on the final bit using the combinational next CRC so the
    // result is ready in the same edge that enters DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            sh_q   <= '0;
            mask_q <= '0;
            crc_q  <= '0;
            cnt_q  <= '0;
            cw_q   <= '0;
        end else if (accept) begin
            data_q <= dIn;
            sh_q   <= dIn;
            mask_q <= errMask;
            crc_q  <= INIT;
            cnt_q  <= '0;
        end else if (state == SHIFT) begin
            crc_q <= crc_next;
            sh_q  <= sh_q << 1;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_bit) begin
                cw_q <= {data_q, crc_next} ^ mask_q;
            end
        end
    end

    assign dInReady = (state == IDLE);
    assign busy     = (state != IDLE);
    assign cwValid  = (state == DONE);
    assign cw       = cw_q;

endmodule

// File: tb/tb_crc_encoder.sv
// Bench for crc_encoder: directed vectors, backpressure, error masks,
// asynchronous reset mid-word and back-to-back random words. Expected
// codewords come from GF(2) long division of data*x^16 by the generator.
module tb_crc_encoder;

    logic        clk;
    logic        rst;
    logic        dInValid;
    logic [15:0] dIn;
    logic [31:0] errMask;
    logic        dInReady;
    logic        cwValid;
    logic [31:0] cw;
    logic        cwReady;
    logic        busy;

    int          n_checks;
    int          n_errors;
    logic [31:0] exp_q[$];
    time         last_valid_t;

    crc_encoder dut (
        .clk      (clk),
        .rst      (rst),
        .dInValid (dInValid),
        .dIn      (dIn),
        .errMask  (errMask),
        .dInReady (dInReady),
        .cwValid  (cwValid),
        .cw       (cw),
        .cwReady  (cwReady),
        .busy     (busy)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Remainder of a 32-bit polynomial modulo x^16 + 0x1021 over GF(2).
    function automatic logic [15:0] gf2_mod(input logic [31:0] x);
        logic [31:0] r;
        logic [16:0] g;
        r = x;
        g = 17'h11021;
        for (int i = 31; i >= 16; i--) begin
            if (r[i]) r = r ^ ({15'd0, g} << (i - 16));
        end
        return r[15:0];
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the encoder idle; returns at a negedge with
    // the encoder idle again. hold = cycles of cwReady low after cwValid.
    task automatic send_word(input logic [15:0] data, input logic [31:0] mask,
                             input int hold, input string tag,
                             output logic [31:0] cw_out);
        logic [31:0] exp_cw;
        int          lat;
        bit          seen;
        check_eq({tag, "_rdy_idle"}, {31'd0, dInReady}, 32'd1);
        dInValid = 1'b1;
        dIn      = data;
        errMask  = mask;
        cwReady  = (hold == 0);
        exp_q.push_back({data, gf2_mod({data, 16'h0000})} ^ mask);
        @(negedge clk);
        lat  = 0;
        seen = 0;
        while (lat < 40 && !seen) begin
            // Inputs wander while busy; none of it may be picked up.
            dInValid = 1'($urandom_range(0, 1));
            dIn      = 16'($urandom);
            errMask  = $urandom;
            @(negedge clk);
            lat++;
            if (cwValid) begin
                seen = 1;
            end else if (lat == 1) begin
                check_eq({tag, "_busy"}, {31'd0, busy}, 32'd1);
                check_eq({tag, "_rdy_shift"}, {31'd0, dInReady}, 32'd0);
            end
        end
        dInValid = 1'b0;
        check_eq({tag, "_latency"}, 32'(lat), 32'd16);
        last_valid_t = $time;
        exp_cw = exp_q.pop_front();
        check_eq({tag, "_cw"}, cw, exp_cw);
        check_eq({tag, "_rdy_done"}, {31'd0, dInReady}, 32'd0);
        for (int h = 0; h < hold; h++) begin
            dInValid = 1'($urandom_range(0, 1));
            dIn      = 16'($urandom);
            @(negedge clk);
            check_eq({tag, "_hold_valid"}, {31'd0, cwValid}, 32'd1);
            check_eq({tag, "_hold_cw"}, cw, exp_cw);
        end
        dInValid = 1'b0;
        cwReady  = 1'b1;
        @(negedge clk);
        check_eq({tag, "_valid_fall"}, {31'd0, cwValid}, 32'd0);
        check_eq({tag, "_rdy_back"}, {31'd0, dInReady}, 32'd1);
        cw_out = exp_cw;
    endtask

    initial begin
        logic [31:0] got_cw;
        logic [15:0] rnd;
        time         prev_t;
        bit          spurious;
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        dInValid = 1'b0;
        dIn      = '0;
        errMask  = '0;
        cwReady  = 1'b1;

        // Reset state
        #3;
        check_eq("reset_valid", {31'd0, cwValid}, 32'd0);
        check_eq("reset_cw", cw, 32'd0);
        check_eq("reset_busy", {31'd0, busy}, 32'd0);
        check_eq("reset_rdy", {31'd0, dInReady}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors with literal expectations
        send_word(16'h0001, 32'h0, 0, "w0001", got_cw);
        check_eq("lit_0001", got_cw, 32'h0001_1021);
        send_word(16'h0010, 32'h0, 0, "w0010", got_cw);
        check_eq("lit_0010", got_cw, 32'h0010_1231);
        send_word(16'h0011, 32'h0, 0, "w0011", got_cw);
        check_eq("lit_0011", got_cw, 32'h0011_0210);
        send_word(16'h0000, 32'h0, 0, "w0000", got_cw);
        check_eq("lit_0000", got_cw, 32'h0000_0000);

        // Backpressure
        send_word(16'h0002, 32'h0, 5, "bp", got_cw);
        check_eq("lit_0002", got_cw, 32'h0002_2042);

        // Error injection
        send_word(16'h0010, 32'h0000_0001, 0, "mask_lo", got_cw);
        check_eq("lit_mask_lo", got_cw, 32'h0010_1230);
        send_word(16'h0010, 32'h0001_0000, 0, "mask_hi", got_cw);
        check_eq("lit_mask_hi", got_cw, 32'h0011_1231);

        // Asynchronous reset mid-SHIFT (after 8 shift edges, cnt == 8)
        dInValid = 1'b1;
        dIn      = 16'hBEEF;
        errMask  = '0;
        cwReady  = 1'b1;
        @(negedge clk);
        dInValid = 1'b0;
        for (int i = 0; i < 8; i++) @(negedge clk);
        check_eq("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_rst_valid", {31'd0, cwValid}, 32'd0);
        check_eq("async_rst_busy", {31'd0, busy}, 32'd0);
        check_eq("async_rst_rdy", {31'd0, dInReady}, 32'd1);
        check_eq("async_rst_cw", cw, 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        spurious = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cwValid) spurious = 1;
        end
        check_eq("no_valid_after_rst", {31'd0, spurious}, 32'd0);
        send_word(16'h0001, 32'h0, 0, "post_rst", got_cw);
        check_eq("lit_post_rst", got_cw, 32'h0001_1021);

        // Back-to-back random words: 18-cycle period, zero remainder
        prev_t = 0;
        for (int k = 0; k < 8; k++) begin
            rnd = 16'($urandom);
            send_word(rnd, 32'h0, 0, "rand", got_cw);
            check_eq("rand_remainder", {16'd0, gf2_mod(cw)}, 32'd0);
            if (k > 0) check_eq("rand_period", 32'((last_valid_t - prev_t) / 10), 32'd18);
            prev_t = last_valid_t;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
